// File: rtl/bridge_pkg.sv
// Shared address map, register-select encoding and seven-segment glyph helper
// for the CPU data-port bridge.
package bridge_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_DISP   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TCNT   = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TDIV   = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN    = 32'hFFFF_F078;

    typedef enum logic [2:0] {
        SEL_DRAM = 3'd0,
        SEL_DISP = 3'd1,
        SEL_TCNT = 3'd2,
        SEL_TDIV = 3'd3,
        SEL_LED  = 3'd4,
        SEL_SW   = 3'd5,
        SEL_BTN  = 3'd6,
        SEL_NONE = 3'd7
    } reg_sel_e;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bridge_io_seg_scan.sv
// Multiplexed 8-digit seven-segment driver: one digit lit per SCAN_DIV cycles,
// with registered digit enables and segment drive.
module seg_scan #(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] value,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    import bridge_pkg::*;

    localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       dig_en_r;
    logic [7:0]       dig_seg_r;
    logic [3:0]       nibble_s;

    assign nibble_s = value[{idx_r, 2'b00} +: 4];

    // Scan counter and digit index advance.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            scan_cnt_r <= '0;
            idx_r      <= 3'd0;
        end else if (scan_cnt_r == CNT_LAST) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 3'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Registered pin drive, one cycle behind the digit index.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            dig_en_r  <= 8'hFE;
            dig_seg_r <= 8'hC0;
        end else begin
            dig_en_r  <= ~(8'd1 << idx_r);
            dig_seg_r <= hex2seg(nibble_s);
        end
    end

    assign dig_en  = dig_en_r;
    assign dig_seg = dig_seg_r;

endmodule

// File: rtl/bridge_io.sv
// CPU data-port responder: decodes DRAM vs. peripheral space, owns the LED,
// switch, button, timer and display registers, and returns load data combinationally.
module bridge_io #(
    parameter int SCAN_DIV    = 20000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);
    import bridge_pkg::*;

    reg_sel_e   sel_s;
    logic       dram_sel_s;
    logic       led_we_s, disp_we_s, tcnt_we_s, tdiv_we_s;
    logic       tick_s;
    logic [31:0] rdata_s;

    logic [23:0] led_r;
    logic [31:0] disp_r;
    logic [31:0] tcnt_r;
    logic [31:0] tdiv_r;
    logic [31:0] presc_r;
    logic [SYNC_STAGES-1:0][23:0] sw_sync_r;
    logic [SYNC_STAGES-1:0][4:0]  btn_sync_r;

    // Address decode; only exact register addresses select a register.
    always_comb begin
        sel_s = SEL_NONE;
        if (Bus_addr < PERIPH_BASE) begin
            sel_s = SEL_DRAM;
        end else begin
            case (Bus_addr)
                ADDR_DISP: sel_s = SEL_DISP;
                ADDR_TCNT: sel_s = SEL_TCNT;
                ADDR_TDIV: sel_s = SEL_TDIV;
                ADDR_LED:  sel_s = SEL_LED;
                ADDR_SW:   sel_s = SEL_SW;
                ADDR_BTN:  sel_s = SEL_BTN;
                default:   sel_s = SEL_NONE;
            endcase
        end
    end

    assign dram_sel_s = (sel_s == SEL_DRAM);
    assign led_we_s   = Bus_wen & (sel_s == SEL_LED);
    assign disp_we_s  = Bus_wen & (sel_s == SEL_DISP);
    assign tcnt_we_s  = Bus_wen & (sel_s == SEL_TCNT);
    assign tdiv_we_s  = Bus_wen & (sel_s == SEL_TDIV);
    assign tick_s     = (presc_r == tdiv_r);

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wen   = Bus_wen & dram_sel_s;
    assign dram_wdata = Bus_wdata;

    // Writable peripheral registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            led_r  <= 24'd0;
            disp_r <= 32'd0;
            tdiv_r <= 32'd0;
        end else begin
            if (led_we_s) led_r <= Bus_wdata[23:0];
            if (disp_we_s) disp_r <= Bus_wdata;
            if (tdiv_we_s) tdiv_r <= Bus_wdata;
        end
    end

    // Timer: a direct TCNT load beats a coincident tick; any timer write restarts the prescaler.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            tcnt_r  <= 32'd0;
            presc_r <= 32'd0;
        end else begin
            if (tcnt_we_s) begin
                tcnt_r <= Bus_wdata;
            end else if (tick_s) begin
                tcnt_r <= tcnt_r + 32'd1;
            end
            if (tcnt_we_s || tdiv_we_s || tick_s) begin
                presc_r <= 32'd0;
            end else begin
                presc_r <= presc_r + 32'd1;
            end
        end
    end

    // Input synchronizers for the asynchronous board switches and buttons.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_sync_r  <= '0;
            btn_sync_r <= '0;
        end else begin
            sw_sync_r  <= {sw_sync_r[SYNC_STAGES-2:0], sw};
            btn_sync_r <= {btn_sync_r[SYNC_STAGES-2:0], button};
        end
    end

    // Load data mux, driven by the decoded address only.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            SEL_DRAM: rdata_s = dram_rdata;
            SEL_DISP: rdata_s = disp_r;
            SEL_TCNT: rdata_s = tcnt_r;
            SEL_TDIV: rdata_s = tdiv_r;
            SEL_LED:  rdata_s = {8'd0, led_r};
            SEL_SW:   rdata_s = {8'd0, sw_sync_r[SYNC_STAGES-1]};
            SEL_BTN:  rdata_s = {27'd0, btn_sync_r[SYNC_STAGES-1]};
            default:  rdata_s = 32'd0;
        endcase
    end

    assign Bus_rdata = rdata_s;
    assign led       = led_r;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .value   (disp_r),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule

// File: doc/bridge_io.md
# bridge_io

Bus-side responder for the CPU data port: decodes every `Bus_addr`, routes accesses to the data RAM or to the memory-mapped peripheral block, and returns `Bus_rdata` in the same cycle. It owns the LED, switch, button, timer and 8-digit seven-segment display registers. It sits between the CPU's MEM-stage bus and the board-level DRAM and I/O pins.

## Interface
Parameters:
- `SCAN_DIV`, 20000: `cpu_clk` cycles each display digit is lit (≥2).
- `SYNC_STAGES`, 2: flip-flop stages on `sw` and `button` (≥2).

Ports:
- `cpu_clk`  in  1  system clock, all state on rising edge.
- `cpu_rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `Bus_addr`  in  32  byte address from the CPU MEM stage.
- `Bus_wen`  in  1  write strobe, one cycle per store.
- `Bus_wdata`  in  32  store data.
- `Bus_rdata`  out  32  load data, combinational.
- `dram_addr`  out  14  word address, `Bus_addr[15:2]`.
- `dram_wen`  out  1  DRAM write enable.
- `dram_wdata`  out  32  equals `Bus_wdata`.
- `dram_rdata`  in  32  asynchronous-read DRAM output.
- `sw`  in  24  board switches, asynchronous.
- `button`  in  5  board buttons, asynchronous, active-high.
- `led`  out  24  LED drive.
- `dig_en`  out  8  digit enables, active-low.
- `dig_seg`  out  8  segments `{dp,g,f,e,d,c,b,a}`, active-low.

## Operation
- Address map:
  - Addresses `< 0xFFFF_F000` are DRAM.
  - `0xFFFF_F000` DISP, R/W.
  - `0xFFFF_F020` TCNT, R/W.
  - `0xFFFF_F024` TDIV, R/W.
  - `0xFFFF_F060` LED, R/W, bits [23:0].
  - `0xFFFF_F070` SW, RO, zero-extended.
  - `0xFFFF_F078` BTN, RO, zero-extended.
  - Any other `0xFFFF_Fxxx` address reads 0. Writes to it are ignored.
- `dram_wen = Bus_wen & dram_sel`. Peripheral stores never reach DRAM.
- Writes to SW or BTN are ignored.
- Reads are combinational. `Bus_rdata` is selected by address alone; `Bus_wen` does not affect it.
- Synchronizers: `sw` and `button` each pass through `SYNC_STAGES` flops. SW and BTN read the last stage.
- Timer:
  - A prescaler counts from 0 to TDIV. When it reaches TDIV it returns to 0 and TCNT increments by 1.
  - TCNT wraps `0xFFFF_FFFF` → 0.
  - A TCNT write loads `Bus_wdata` and clears the prescaler. The write wins over a same-cycle tick.
  - A TDIV write clears the prescaler.
  - TDIV = 0 increments TCNT every cycle.
- Display:
  - The scan counter counts 0..`SCAN_DIV-1`. On wrap, digit index `idx` advances 0→7, then back to 0.
  - `dig_en = ~(8'b1 << idx)`.
  - `dig_seg` is the hex glyph of `DISP[4*idx+3 : 4*idx]`, with dp always 1 (off).

## Timing
- Load latency is 0 cycles: `Bus_rdata` is valid in the same cycle as `Bus_addr`.
- A stored peripheral value is readable from the cycle after the write edge. DRAM write timing belongs to the DRAM.
- Pin-to-readback latency is `SYNC_STAGES` edges for switches and buttons.
- `dig_en` / `dig_seg` are registered and change 1 cycle after the scan wrap.
- Reset values:
  - `led` = 0; DISP = 0; TCNT = 0; TDIV = 0.
  - Prescaler, scan counter and `idx` = 0; sync flops = 0.
  - `dig_en` = `0xFE`; `dig_seg` = `0xC0` (glyph "0").
- Reset mid-operation:
  - All the registers above return to their reset values immediately.
  - `Bus_rdata` keeps tracking the address decode.
  - `dram_wen` is gated by `Bus_wen` only; the bridge does not mask it during reset.

## Structure
- Package `bridge_pkg` holds:
  - address constants `ADDR_DISP`, `ADDR_TCNT`, `ADDR_TDIV`, `ADDR_LED`, `ADDR_SW`, `ADDR_BTN`, `PERIPH_BASE`;
  - the function `hex2seg(nibble) -> 8-bit active-low glyph`.
- Sub-module `seg_scan`:
  - inputs `cpu_clk`, `cpu_rst`, value[31:0];
  - outputs `dig_en`, `dig_seg`;
  - owns the scan counter and `idx`.
- The top level holds the decode, read mux, registers, synchronizers and timer.

## Test plan
- Store `0x00A5_5A5A` to `0xFFFF_F060` → `led = 0xA55A5A` next cycle, `dram_wen` stays 0, and a load from `0xFFFF_F060` returns `0x00A5_5A5A`.
- Store to `0x0000_0010` → `dram_wen = 1`, `dram_addr = 4`, `dram_wdata` equals the store data; a load at the same address returns `dram_rdata` in the same cycle.
- Set `sw = 0x123456` → a SW read returns `0x0012_3456` exactly `SYNC_STAGES` edges later; a store to SW is ignored.
- TDIV = 3, TCNT ← `0xFFFF_FFFE` → TCNT reads `0xFFFF_FFFF` after 4 cycles, then 0 after 4 more; a TCNT write on a tick cycle loads the written value.
- `SCAN_DIV = 4`, DISP = `0x8765_4321` → `dig_en` sequence `FE, FD, …, 7F, FE`, with `dig_seg` = `0xF9` for digit 0 and `0x80` for digit 7.
- Assert `cpu_rst` mid-scan with TCNT counting → `led`, TCNT and `idx` clear without waiting for a clock edge; `dig_en = 0xFE`, `dig_seg = 0xC0`.
